// File: rtl/mdu_iter.sv
// Iterative multiply / divide / multiply-accumulate unit owning the HI/LO pair.
// Latency: arithmetic ops WIDTH+1 cycles from the start edge to done; MTHI/MTLO write at the start edge, done next cycle.
// Backpressure: busy high while iterating; starts seen while busy are dropped (no queuing), flush aborts without a write.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_MTHI = 3'd6;
  localparam logic [2:0] OP_MTLO = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;    // product upper half / partial remainder
  logic [WIDTH-1:0] acc_lo;    // product lower half + multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] mag_b;     // magnitude of the multiplicand / divisor
  logic [WIDTH-1:0] a_raw;     // original dividend, returned as HI on divide by zero
  logic             is_div;
  logic             is_madd;
  logic             neg_res;   // product / quotient must be negated
  logic             neg_rem;   // remainder follows the dividend sign
  logic             div_zero;

  // Operand decode at the start edge. Ops 0/2/4 are signed; the magnitude of
  // MIN is 2^(WIDTH-1), which still fits when read back as unsigned.
  logic             in_signed;
  logic             in_arith;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Incoming operand sign handling
  always_comb begin
    in_signed = ~op[0];
    in_arith  = ~(op[2] & op[1]);
    a_neg     = in_signed & a[WIDTH-1];
    b_neg     = in_signed & b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  // Per-iteration arithmetic
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = ~div_diff[WIDTH];
  end

  // Final sign fixup, accumulate and HI/LO selection
  logic [2*WIDTH-1:0] prod, prod_s, mac;
  logic [WIDTH-1:0]   quot_s, rem_s;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Result formation during FIX
  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = neg_res ? -prod : prod;
    mac    = prod_s + (is_madd ? {hi, lo} : {(2*WIDTH){1'b0}});
    quot_s = neg_res ? -acc_lo : acc_lo;
    rem_s  = neg_rem ? -acc_hi : acc_hi;
    if (!is_div) begin
      res_hi = mac[2*WIDTH-1:WIDTH];
      res_lo = mac[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = rem_s;
      res_lo = quot_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: flush beats start in IDLE and aborts RUN/FIX
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !flush && in_arith) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)                  state_nxt = S_IDLE;
        else if (cnt == CW'(1))     state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Datapath, HI/LO and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mag_b    <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      is_madd  <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            if (op == OP_MTHI) begin
              hi   <= a;
              done <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo   <= a;
              done <= 1'b1;
            end else begin
              cnt      <= CW'(WIDTH);
              acc_hi   <= '0;
              acc_lo   <= a_mag;
              mag_b    <= b_mag;
              a_raw    <= a;
              is_div   <= op[2];
              is_madd  <= (op[2:1] == 2'b01);
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= (b == '0);
            end
          end
        end
        S_RUN: begin
          if (!flush) begin
            cnt <= cnt - CW'(1);
            if (is_div) begin
              acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks   = 0;
  int failures = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op; lat = edges after the start edge until done is seen (-1 on timeout).
  // imm=1 drives start on the current negedge instead of waiting for the next one.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit imm, output int lat, output int bcnt);
    if (!imm) @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    lat = -1; bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat, bcnt, dcnt;
  int exp_lat;

  initial begin
    // op,  a,             b,             expected hi,   expected lo
    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA}; // MULT -2*3
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA}; // MULTU
    vecs[2]  = '{3'd6, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFFFFA}; // MTHI 0
    vecs[3]  = '{3'd7, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'hFFFFFFFF}; // MTLO
    vecs[4]  = '{3'd3, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000}; // MADDU carry into HI
    vecs[5]  = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF}; // MADD -1
    vecs[6]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD}; // DIV -7/2
    vecs[7]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000}; // DIV overflow
    vecs[8]  = '{3'd5, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF}; // DIVU by zero
    vecs[9]  = '{3'd5, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}; // DIVU
    vecs[10] = '{3'd4, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF}; // DIV -7/0, no fixup
    vecs[11] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}; // MULT MIN*MIN
    vecs[12] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD}; // DIV 7/-2

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat, bcnt);
      exp_lat = (vecs[i].op >= 3'd6) ? 0 : W + 1;
      chk($sformatf("v%0d_lat", i), lat, exp_lat);
      chk($sformatf("v%0d_busycyc", i), bcnt, exp_lat);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_busy_at_done", i), busy, 0);
    end

    // Start while busy is dropped; flush at cycle 10 aborts with no write.
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (done) dcnt++;
      if (k == 4) begin start = 1'b1; op = 3'd6; a = 32'hDEAD; end
      if (k == 5) chk("ignored_start_busy", busy, 1);
      if (k == 9) flush = 1'b1;
      if (k == 10) chk("flush_busy", busy, 0);
    end
    chk("flush_no_done", dcnt, 0);
    chk("flush_hi_kept", hi, 32'h00000001);
    chk("flush_lo_kept", lo, 32'hFFFFFFFD);

    // flush wins over a simultaneous start in IDLE
    @(negedge clk);
    start = 1'b1; op = 3'd7; a = 32'h1234; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_mtlo_done", done, 0);
    chk("idle_flush_mtlo_lo", lo, 32'hFFFFFFFD);
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_mult_busy", busy, 0);

    // Start in the same cycle as done is accepted
    do_op(3'd0, 32'd3, 32'd4, 1'b0, lat, bcnt);
    chk("b2b_first_lat", lat, W + 1);
    chk("b2b_first_lo", lo, 32'd12);
    do_op(3'd1, 32'd7, 32'd8, 1'b1, lat, bcnt);
    chk("b2b_second_lat", lat, W + 1);
    chk("b2b_second_hi", hi, 32'd0);
    chk("b2b_second_lo", lo, 32'd56);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_div_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b1;
    do_op(3'd0, 32'd3, 32'd4, 1'b0, lat, bcnt);
    chk("post_rst_lat", lat, W + 1);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide/accumulate unit with its own architectural HI/LO pair. Parametrised in datapath width.
- Replaces the single-cycle combinational multiply and HI/LO update inside the processor core.
- Adds divide, unsigned/signed modes, multiply-accumulate, move-to-HI/LO, a start/busy/done handshake and abort.
- The core stalls on busy and reads hi/lo directly.

Parameters:
- WIDTH, 32: operand, HI and LO width. Must be ≥ 4.
- CW, derived as clog2(WIDTH)+1: iteration counter width. Not user-set.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: request strobe, sampled on rising clk.
- op, input, 3: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO.
- a, input, WIDTH: operand A (rs) / dividend / MTHI or MTLO data.
- b, input, WIDTH: operand B (rt) / divisor.
- flush, input, 1: abort the operation in flight.
- busy, output, 1: iteration in progress; new starts are ignored.
- done, output, 1: one-cycle pulse when HI/LO has been updated.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (rst low, asynchronous): busy=0, done=0, hi=0, lo=0, state=IDLE, counter=0. Any operation in flight is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op in 0..5:
  - Latch op; take magnitudes of a and b (signed ops only); record result sign(s).
  - Counter=WIDTH; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, op 6/7:
  - hi<=a (MTHI) or lo<=a (MTLO) at that edge; done=1 the following cycle.
  - busy stays 0. No other register changes.
- RUN: one radix-2 step per cycle, counter decrements. RUN→FIX when counter reaches 1 after its step.
  - Multiply: shift-add on a 2*WIDTH product register.
  - Divide: restoring division, one quotient bit per cycle, WIDTH-bit partial remainder plus one guard bit.
- FIX (one cycle):
  - Apply sign: product negated if signs differ; quotient negated if signs differ; remainder takes dividend's sign.
  - MADD/MADDU add {hi,lo} (2*WIDTH-bit, wraps modulo 2^(2*WIDTH)).
  - Write hi/lo. MULT*: hi=upper, lo=lower. DIV*: lo=quotient, hi=remainder.
  - busy<=0, done<=1 for one cycle, go to IDLE.
- Latency: start accepted at edge N; busy high for edges N+1..N+WIDTH+1; hi/lo update and done rise at edge N+WIDTH+1; busy low at the same edge.
- start while busy=1: ignored, no queuing.
- start in the same cycle as done: accepted, because state is IDLE from the FIX edge onward.
- flush=1 while busy: next edge returns to IDLE, busy=0, no done, hi/lo unchanged.
- flush=1 in IDLE: no effect. flush wins over a simultaneous start.
- Divide by zero: runs full latency, then lo=all ones, hi=a unmodified (sign fixup bypassed).
- Signed overflow (DIV, a=MIN, b=-1): lo=MIN, hi=0. No flag.
- Signed |MIN| handled with a WIDTH+1-bit magnitude or an unsigned interpretation; no sign loss.
- hi/lo hold their value except on a done-producing write or reset.

Test Plan (WIDTH=32):
- MULT a=0xFFFFFFFE, b=3 → done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high 33 cycles. Then MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- MTHI 0, MTLO 0xFFFFFFFF (each done next cycle, busy never high), then MADDU a=1, b=1 → hi=0x00000001, lo=0x00000000. Then MADD a=0xFFFFFFFF, b=1 → hi=0x00000000, lo=0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles. DIVU a=0xFFFFFFFF, b=0x10 → lo=0x0FFFFFFF, hi=0xF.
- MULT in flight; second start at cycle 5 is ignored. flush at cycle 10 → busy=0 next cycle, no done, hi/lo keep prior values. Start coincident with done → accepted, second done 33 cycles later.
- rst low mid-DIV, asynchronously and off a clock edge → busy=0, done=0, hi=lo=0 immediately. After release, a MULT 3×4 → lo=12, hi=0.
